// File: rtl/ctrl_fsm.sv
// Multicycle MIPS-subset controller. Moore-style: every output is decoded
// from the current state plus the latched instruction fields (op/funct);
// only the branch PC write looks at the ALU zero flag combinationally.
module ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       oflow,
  output logic [2:0] aluop,
  output logic       pcwr,
  output logic       irwr,
  output logic       regwr,
  output logic       memwr,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic       extop,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MREAD  = 4'd3,
    S_MWB    = 4'd4,
    S_MWRITE = 4'd5,
    S_EXE    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  state_t state_q;
  state_t state_d;
  logic   ovf_q;

  // R-type arithmetic instruction that goes through EXE/RWB
  function automatic logic is_r_alu(input logic [5:0] o, input logic [5:0] f);
    return (o == OP_RTYPE) && (f == FN_ADDU || f == FN_SUBU || f == FN_SLT);
  endfunction

  // Immediate arithmetic instruction that goes through EXE/RWB
  function automatic logic is_i_alu(input logic [5:0] o);
    return (o == OP_ORI) || (o == OP_LUI) || (o == OP_ADDI);
  endfunction

  // ALU operation for the EXE state
  function automatic logic [2:0] exe_aluop(input logic [5:0] o, input logic [5:0] f);
    logic [2:0] r;
    r = ALU_ADD;
    if (o == OP_RTYPE) begin
      if (f == FN_SUBU)     r = ALU_SUB;
      else if (f == FN_SLT) r = ALU_SLT;
    end else if (o == OP_ORI) begin
      r = ALU_OR;
    end else if (o == OP_LUI) begin
      r = ALU_LUI;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Overflow flag: captured leaving EXE so RWB can suppress an addi write
  always_ff @(posedge clk) begin
    if (rst)                   ovf_q <= 1'b0;
    else if (state_q == S_EXE) ovf_q <= oflow;
    else                       ovf_q <= 1'b0;
  end

  // Next-state and output decode; strobes are forced low while in reset
  always_comb begin
    state_d  = S_FETCH;
    aluop    = ALU_ADD;
    pcwr     = 1'b0;
    irwr     = 1'b0;
    regwr    = 1'b0;
    memwr    = 1'b0;
    alusrc_a = 1'b0;
    alusrc_b = 2'b00;
    extop    = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    pcsrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwr     = 1'b1;
        pcwr     = 1'b1;
        alusrc_b = 2'b01;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        alusrc_b = 2'b11;
        extop    = 1'b1;
        if (op == OP_LW || op == OP_SW)
          state_d = S_MADDR;
        else if (is_r_alu(op, funct) || is_i_alu(op))
          state_d = S_EXE;
        else if (op == OP_BEQ)
          state_d = S_BR;
        else if (op == OP_J || op == OP_JAL || (op == OP_RTYPE && funct == FN_JR))
          state_d = S_JMP;
        else
          state_d = S_FETCH;
      end
      S_MADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        extop    = 1'b1;
        state_d  = (op == OP_LW) ? S_MREAD : S_MWRITE;
      end
      S_MREAD: begin
        state_d = S_MWB;
      end
      S_MWB: begin
        regwr    = 1'b1;
        memtoreg = 2'b01;
        state_d  = S_FETCH;
      end
      S_MWRITE: begin
        memwr   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXE: begin
        alusrc_a = 1'b1;
        alusrc_b = (op == OP_RTYPE) ? 2'b00 : 2'b10;
        extop    = (op == OP_ADDI);
        aluop    = exe_aluop(op, funct);
        state_d  = S_RWB;
      end
      S_RWB: begin
        regdst  = (op == OP_RTYPE) ? 2'b01 : 2'b00;
        regwr   = !((op == OP_ADDI) && ovf_q);
        state_d = S_FETCH;
      end
      S_BR: begin
        alusrc_a = 1'b1;
        aluop    = ALU_SUB;
        pcsrc    = 2'b01;
        pcwr     = zero;
        state_d  = S_FETCH;
      end
      S_JMP: begin
        pcwr  = 1'b1;
        pcsrc = (op == OP_RTYPE) ? 2'b11 : 2'b10;
        if (op == OP_JAL) begin
          regwr    = 1'b1;
          regdst   = 2'b10;
          memtoreg = 2'b10;
        end
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (rst) begin
      pcwr  = 1'b0;
      irwr  = 1'b0;
      regwr = 1'b0;
      memwr = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: directed instructions followed by random instructions
// (random zero/oflow, occasional mid-instruction reset), checked cycle by
// cycle against a per-instruction expected microsequence.
module tb_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       oflow;
  logic [2:0] aluop;
  logic       pcwr, irwr, regwr, memwr, alusrc_a, extop;
  logic [1:0] alusrc_b, regdst, memtoreg, pcsrc;
  logic [3:0] state;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .oflow(oflow),
    .aluop(aluop), .pcwr(pcwr), .irwr(irwr), .regwr(regwr), .memwr(memwr),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .extop(extop), .regdst(regdst),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [20:0] vec_t;
  localparam vec_t STROBES = 21'h003C00;

  typedef enum int {
    K_LW, K_SW, K_ADDU, K_SUBU, K_SLT, K_JR, K_ORI, K_LUI, K_ADDI,
    K_BEQ, K_J, K_JAL, K_BADOP, K_BADFN
  } kind_t;

  vec_t exp_q[$];

  // Packs one cycle's expected outputs: state, aluop, pcwr, irwr, regwr, memwr,
  // alusrc_a, alusrc_b, extop, regdst, memtoreg, pcsrc
  function automatic vec_t rec(input int st, input int alu, input int pw, input int iw,
                               input int rw, input int mw, input int asa, input int asb,
                               input int ext, input int rd, input int m2r, input int pcs);
    return {st[3:0], alu[2:0], pw[0], iw[0], rw[0], mw[0], asa[0], asb[1:0],
            ext[0], rd[1:0], m2r[1:0], pcs[1:0]};
  endfunction

  function automatic vec_t obs();
    return {state, aluop, pcwr, irwr, regwr, memwr, alusrc_a, alusrc_b,
            extop, regdst, memtoreg, pcsrc};
  endfunction

  task automatic chk(input string tag, input vec_t got, input vec_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Instruction encodings; funct is random where the opcode ignores it
  task automatic pick(input kind_t k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (k)
      K_LW:    o = 6'b100011;
      K_SW:    o = 6'b101011;
      K_ADDU:  begin o = 6'b000000; f = 6'b100001; end
      K_SUBU:  begin o = 6'b000000; f = 6'b100011; end
      K_SLT:   begin o = 6'b000000; f = 6'b101010; end
      K_JR:    begin o = 6'b000000; f = 6'b001000; end
      K_ORI:   o = 6'b001101;
      K_LUI:   o = 6'b001111;
      K_ADDI:  o = 6'b001000;
      K_BEQ:   o = 6'b000100;
      K_J:     o = 6'b000010;
      K_JAL:   o = 6'b000011;
      K_BADFN: begin o = 6'b000000; f = 6'b111111; end
      default: begin
        case ($urandom_range(0, 2))
          0:       o = 6'b111111;
          1:       o = 6'b010000;
          default: o = 6'b000110;
        endcase
      end
    endcase
  endtask

  // Expected microsequence for one instruction, given zero/oflow per cycle
  task automatic build(input kind_t k, input logic [7:0] zv, input logic [7:0] ov);
    int alu;
    int is_r;
    exp_q.delete();
    exp_q.push_back(rec(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    case (k)
      K_LW: begin
        exp_q.push_back(rec(2, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        exp_q.push_back(rec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
      end
      K_SW: begin
        exp_q.push_back(rec(2, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        exp_q.push_back(rec(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      end
      K_ADDU, K_SUBU, K_SLT, K_ORI, K_LUI, K_ADDI: begin
        is_r = (k == K_ADDU || k == K_SUBU || k == K_SLT) ? 1 : 0;
        case (k)
          K_SUBU:  alu = 3;
          K_SLT:   alu = 2;
          K_ORI:   alu = 1;
          K_LUI:   alu = 4;
          default: alu = 0;
        endcase
        exp_q.push_back(rec(6, alu, 0, 0, 0, 0, 1, is_r ? 0 : 2,
                            (k == K_ADDI) ? 1 : 0, 0, 0, 0));
        exp_q.push_back(rec(7, 0, 0, 0, (k == K_ADDI && ov[2]) ? 0 : 1, 0, 0, 0, 0,
                            is_r, 0, 0));
      end
      K_BEQ:  exp_q.push_back(rec(8, 3, int'(zv[2]), 0, 0, 0, 1, 0, 0, 0, 0, 1));
      K_J:    exp_q.push_back(rec(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
      K_JAL:  exp_q.push_back(rec(9, 0, 1, 0, 1, 0, 0, 0, 0, 2, 2, 2));
      K_JR:   exp_q.push_back(rec(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
      default: ;
    endcase
  endtask

  // Runs one instruction from a FETCH cycle (called at posedge+1).
  // zo < 0 randomizes zero/oflow, otherwise holds them at zo.
  // abort_at >= 0 raises rst in that cycle of the instruction.
  task automatic run(input kind_t k, input int zo, input int abort_at, input string name);
    logic [7:0] zv, ov;
    logic [5:0] o, f;
    vec_t want;
    for (int i = 0; i < 8; i++) begin
      zv[i] = 1'($urandom_range(0, 1));
      ov[i] = 1'($urandom_range(0, 1));
    end
    if (zo >= 0) begin
      zv = {8{zo[0]}};
      ov = {8{zo[0]}};
    end
    pick(k, o, f);
    op    = o;
    funct = f;
    build(k, zv, ov);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      zero  = zv[i];
      oflow = ov[i];
      if (i == abort_at) rst = 1'b1;
      #1;
      want = exp_q[i];
      if (i == abort_at) want = want & ~STROBES;
      chk($sformatf("%s cyc%0d", name, i), obs(), want);
      chk($sformatf("%s cyc%0d one_write", name, i), {20'b0, regwr & memwr}, 21'b0);
      chk($sformatf("%s cyc%0d irwr_fetch", name, i), {20'b0, irwr & (state != 4'd0)}, 21'b0);
      if (i == abort_at) begin
        @(posedge clk);
        #1;
        chk($sformatf("%s abort_fetch", name), obs(), rec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    op    = 6'b0;
    funct = 6'b0;
    zero  = 1'b0;
    oflow = 1'b0;
    @(posedge clk);
    #1;
    chk("reset0", obs(), rec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("reset1", obs(), rec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    rst = 1'b0;

    run(K_LW,    -1, -1, "lw");
    run(K_BEQ,    1, -1, "beq_z1");
    run(K_BEQ,    0, -1, "beq_z0");
    run(K_ADDI,   1, -1, "addi_ovf");
    run(K_ADDI,   0, -1, "addi_noovf");
    run(K_JAL,   -1, -1, "jal");
    run(K_JR,    -1, -1, "jr");
    run(K_J,     -1, -1, "j");
    run(K_BADOP, -1, -1, "badop");
    run(K_BADFN, -1, -1, "badfn");
    run(K_ADDU,  -1, -1, "addu");
    run(K_SUBU,  -1, -1, "subu");
    run(K_SLT,   -1, -1, "slt");
    run(K_ORI,   -1, -1, "ori");
    run(K_LUI,   -1, -1, "lui");
    run(K_SW,    -1, -1, "sw");
    run(K_SW,    -1,  3, "sw_rst_mwrite");
    run(K_LW,    -1,  4, "lw_rst_mwb");
    run(K_JAL,   -1,  2, "jal_rst_jmp");

    for (int n = 0; n < 200; n++) begin
      kind_t k;
      int ab;
      k  = kind_t'($urandom_range(0, 13));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run(k, -1, ab, $sformatf("rnd%0d_%s", n, k.name()));
    end

    #1;
    chk("final_fetch", obs(), rec(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction[31:26] from the instruction register (IR), stable from DECODE onward.
REQ-005 funct  in  6  instruction[5:0] from the IR.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 oflow  in  1  ALU signed-overflow flag.
REQ-008 aluop  out  3  ALU opcode: 000 add, 001 or, 010 slt, 011 sub, 100 lui; no other values driven.
REQ-009 pcwr  out  1  PC write enable.
REQ-010 irwr  out  1  IR write enable.
REQ-011 regwr  out  1  register-file write enable.
REQ-012 memwr  out  1  data-memory write enable.
REQ-013 alusrc_a  out  1  ALU A select: 0 = PC, 1 = rs.
REQ-014 alusrc_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = ext(imm), 11 = ext(imm)<<2.
REQ-015 extop  out  1  immediate extension: 1 = sign, 0 = zero.
REQ-016 regdst  out  2  write-register select: 00 = rt, 01 = rd, 10 = $31.
REQ-017 memtoreg  out  2  write-data select: 00 = ALUOut, 01 = memory data register (MDR), 10 = PC.
REQ-018 pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
REQ-019 state  out  4  current state code, for debug only.

Function
REQ-020 Multicycle Moore-style controller; outputs are decoded from state, op and funct only, with no combinational path from zero/oflow except pcwr in BR.
REQ-021 Decoded instructions (op/funct):
  - R-type, op 000000: addu funct 100001, subu 100011, slt 101010, jr 001000.
  - I-type and jumps: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, addi 001000, j 000010, jal 000011.
REQ-022 State codes: FETCH 0, DECODE 1, MADDR 2, MREAD 3, MWB 4, MWRITE 5, EXE 6, RWB 7, BR 8, JMP 9; codes 10-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-023 Any output not listed for a state is 0.
REQ-024 FETCH: irwr=1, pcwr=1, alusrc_b=01, aluop=000, pcsrc=00; next state DECODE.
REQ-025 DECODE: alusrc_b=11, extop=1, aluop=000 (branch target into ALUOut). Next state by instruction:
  - lw/sw -> MADDR
  - addu/subu/slt/ori/lui/addi -> EXE
  - beq -> BR
  - j/jal/jr -> JMP
  - undefined op/funct -> FETCH
REQ-026 MADDR: alusrc_a=1, alusrc_b=10, extop=1, aluop=000; next MREAD for lw, MWRITE for sw.
REQ-027 MREAD -> MWB with no strobes; MWB: regwr=1, regdst=00, memtoreg=01; next FETCH.
REQ-028 MWRITE: memwr=1; next FETCH.
REQ-029 EXE: alusrc_a=1; alusrc_b=00 for R-type, else 10; extop=1 for addi, else 0. aluop: addu 000, subu 011, slt 010, ori 001, lui 100, addi 000. Next RWB.
REQ-030 Internal flag ovf_q is loaded with oflow at the EXE->RWB edge, and cleared in every other state.
REQ-031 RWB: memtoreg=00; regdst=01 for R-type, 00 otherwise; regwr=1 except addi with ovf_q=1 (regwr=0, write suppressed); next FETCH.
REQ-032 BR: alusrc_a=1, alusrc_b=00, aluop=011, pcsrc=01, pcwr=zero; next FETCH.
REQ-033 JMP: pcwr=1; pcsrc=10 for j/jal, 11 for jr. jal additionally drives regwr=1, regdst=10, memtoreg=10 (PC already holds PC+4). Next FETCH.
REQ-034 Cycle counts, FETCH to FETCH inclusive of FETCH: lw 5, sw 4, R-type/ori/lui/addi 4, beq 3, j/jal/jr 3, undefined 2.
REQ-035 At most one of regwr/memwr is high in any cycle; irwr is high only in FETCH.

Reset
REQ-036 While rst=1, every strobe (pcwr, irwr, regwr, memwr) SHALL be 0 regardless of state.
REQ-037 On the first edge with rst=1, state<=FETCH and ovf_q<=0; the first FETCH strobes appear in the cycle after rst deasserts.
REQ-038 Asserting rst in any state, mid-instruction, abandons the instruction; no pending regwr/memwr is issued afterward.

Verification
REQ-039 lw (op=100011): state sequence 0,1,2,3,4,0; MWB cycle shows regwr=1, regdst=00, memtoreg=01; no memwr.
REQ-040 beq, zero=1 then zero=0: BR cycle shows aluop=011, pcsrc=01, and pcwr=1 and 0 respectively; both return to FETCH.
REQ-041 addi, oflow=1 during EXE -> RWB regwr=0; repeated with oflow=0 -> regwr=1, regdst=00.
REQ-042 jal: sequence 0,1,9,0; JMP cycle shows pcwr=1, pcsrc=10, regwr=1, regdst=10, memtoreg=10. jr: pcsrc=11, regwr=0.
REQ-043 op=111111 -> sequence 0,1,0 with no regwr/memwr; rst in MWRITE -> memwr=0 that cycle, state=0 next.
REQ-044 Each of addu/subu/slt/ori/lui in EXE -> aluop 000/011/010/001/100; alusrc_b 00 for R-type, 10 otherwise.
